// File: rtl/regseq_pkg.sv
// Shared definitions for the register-file sequencer: default widths,
// request opcodes and FSM state constants.
package regseq_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    // Request opcodes as carried on req_op.
    typedef enum logic {
        OP_READ2 = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // FSM states, kept as plain constants so the encoding is visible in waves.
    typedef logic [2:0] state_t;
    localparam state_t IDLE = 3'd0;
    localparam state_t RD_A = 3'd1;
    localparam state_t RD_B = 3'd2;
    localparam state_t RESP = 3'd3;
    localparam state_t WR   = 3'd4;

endpackage

// File: rtl/regfile_sequencer.sv
// Serialises operand fetches (rs1 then rs2) and writebacks onto the single
// address port of an asynchronous-read register file. Requests are taken
// only in IDLE; operands come back on a valid/ready response channel.
module regfile_sequencer
    import regseq_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b,
    output logic              wr_done,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] rs1_reg;
    logic [ADDR_W-1:0] rs2_reg;
    logic [ADDR_W-1:0] rd_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic              addr_zero;
    logic [DATA_W-1:0] rdata_masked;

    // Register 0 reads as zero regardless of what the file array holds.
    assign addr_zero    = ZERO_EN && (rf_addr == '0);
    assign rdata_masked = addr_zero ? '0 : rf_rdata;

    assign rsp_a = a_reg;
    assign rsp_b = b_reg;

    // Next-state selection; the opcode is consumed here, so the chosen
    // state itself is the latched record of the operation.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = (op_t'(req_op) == OP_WRITE) ? WR : RD_A;
                end
            end
            RD_A:    state_next = RD_B;
            RD_B:    state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            WR:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags and register-file port drive, decoded from the state.
    always_comb begin
        req_ready = (state_reg == IDLE);
        rsp_valid = (state_reg == RESP);
        wr_done   = (state_reg == WR);
        rf_addr   = '0;
        rf_we     = 1'b0;
        rf_wdata  = '0;
        case (state_reg)
            RD_A: rf_addr = rs1_reg;
            RD_B: rf_addr = rs2_reg;
            WR: begin
                rf_addr  = rd_reg;
                rf_wdata = wdata_reg;
                // Reset in the write cycle must not corrupt the file.
                rf_we    = !rst && !(ZERO_EN && (rd_reg == '0));
            end
            default: ;
        endcase
    end

    // State register, request capture and operand capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rs1_reg   <= '0;
            rs2_reg   <= '0;
            rd_reg    <= '0;
            wdata_reg <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && req_valid) begin
                rs1_reg   <= req_rs1;
                rs2_reg   <= req_rs2;
                rd_reg    <= req_rd;
                wdata_reg <= req_wdata;
            end
            if (state_reg == RD_A) begin
                a_reg <= rdata_masked;
            end
            if (state_reg == RD_B) begin
                b_reg <= rdata_masked;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a behavioural register file sits on the rf_*
// port, a driver issues requests and pushes expected responses, and a
// negedge monitor pops and compares whenever the DUT presents a result.
module tb_regfile_sequencer;
    import regseq_pkg::*;

    localparam int AW = ADDR_W_DEF;
    localparam int DW = DATA_W_DEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_op;
    logic [AW-1:0] req_rs1;
    logic [AW-1:0] req_rs2;
    logic [AW-1:0] req_rd;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_a;
    logic [DW-1:0] rsp_b;
    logic          wr_done;
    logic [AW-1:0] rf_addr;
    logic          rf_we;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata;

    always #5 clk = ~clk;

    regfile_sequencer #(.ADDR_W(AW), .DATA_W(DW), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
        .wr_done(wr_done),
        .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    // Register file: 32x32, combinational read, write on posedge.
    logic [DW-1:0] rf_mem [32];
    logic          preload;

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'h5A5A_0000 | 32'(i) | 32'h0000_0100;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
        end else if (rf_we) begin
            rf_mem[rf_addr] <= rf_wdata;
        end
    end
    assign rf_rdata = rf_mem[rf_addr];

    // Reference model: architectural register contents.
    logic [DW-1:0] ref_regs [32];

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            acc;
    } rd_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          we;
        int            acc;
    } wr_exp_t;

    rd_exp_t rq [$];
    wr_exp_t wq [$];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int rdy_mode = 0;   // 0 random, 1 hold low, 2 hold high

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] r);
        return (r == 0) ? '0 : ref_regs[r];
    endfunction

    // Consumer-side ready generation.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = ($urandom_range(0, 2) != 0);
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares responses and write strobes as the DUT presents them.
    initial begin
        logic          prev_v = 1'b0;
        logic          prev_r = 1'b0;
        logic          prev_wd = 1'b0;
        logic [DW-1:0] held_a = '0;
        logic [DW-1:0] held_b = '0;
        rd_exp_t       re;
        wr_exp_t       we;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v  = 1'b0;
                prev_r  = 1'b0;
                prev_wd = 1'b0;
            end else begin
                if (rsp_valid) begin
                    check("req_ready_in_resp", 32'(req_ready), 32'd0);
                    if (!prev_v) begin
                        if (rq.size() == 0) fail_now("unexpected_rsp");
                        else check("rsp_latency", 32'(edge_cnt), 32'(rq[0].acc + 2));
                    end else if (!prev_r) begin
                        check("rsp_a_stable", rsp_a, held_a);
                        check("rsp_b_stable", rsp_b, held_b);
                    end
                    held_a = rsp_a;
                    held_b = rsp_b;
                    if (rsp_ready && rq.size() != 0) begin
                        re = rq.pop_front();
                        $display("rsp  a=%h b=%h (exp %h %h)", rsp_a, rsp_b, re.a, re.b);
                        check("rsp_a", rsp_a, re.a);
                        check("rsp_b", rsp_b, re.b);
                    end
                end
                if (wr_done) begin
                    if (prev_wd) fail_now("wr_done_width");
                    if (wq.size() == 0) begin
                        fail_now("unexpected_wr");
                    end else begin
                        we = wq.pop_front();
                        $display("wr   addr=%0d data=%h we=%0d (exp we=%0d)", rf_addr, rf_wdata, rf_we, we.we);
                        check("rf_we", 32'(rf_we), 32'(we.we));
                        check("wr_latency", 32'(edge_cnt), 32'(we.acc));
                        if (we.we) begin
                            check("rf_addr", 32'(rf_addr), 32'(we.addr));
                            check("rf_wdata", rf_wdata, we.data);
                        end
                    end
                end else begin
                    check("rf_we_outside_wr", 32'(rf_we), 32'd0);
                end
                prev_v  = rsp_valid;
                prev_r  = rsp_ready;
                prev_wd = wr_done;
            end
        end
    end

    // Issue one request; abort=1 asserts reset during the write cycle.
    task automatic issue(input logic op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic [DW-1:0] wd, input bit abort);
        bit      got = 1'b0;
        int      acc;
        rd_exp_t re;
        wr_exp_t we;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_rd    = rd;
        req_wdata = wd;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        if (!got) begin
            fail_now("req_accept_timeout");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = edge_cnt;
        req_valid = 1'b0;
        if (op == OP_WRITE) begin
            $display("req  WRITE rd=%0d wdata=%h abort=%0d", rd, wd, abort);
            if (abort) begin
                rst = 1'b1;
                #1;
                check("rst_in_wr_we", 32'(rf_we), 32'd0);
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                we.addr = rd;
                we.data = wd;
                we.we   = (rd != 0);
                we.acc  = acc;
                wq.push_back(we);
                if (rd != 0) ref_regs[rd] = wd;
            end
        end else begin
            $display("req  READ2 rs1=%0d rs2=%0d", rs1, rs2);
            re.a   = ref_read(rs1);
            re.b   = ref_read(rs2);
            re.acc = acc;
            rq.push_back(re);
        end
    endtask

    task automatic wait_rsp();
        bit got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        if (!got) fail_now("rsp_valid_timeout");
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int k = 0; k < 500 && !done; k++) begin
            @(negedge clk);
            if (rq.size() == 0 && wq.size() == 0 && req_ready) done = 1'b1;
        end
        if (!done) fail_now("drain_timeout");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] a0;
        logic [DW-1:0] b0;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        rst = 1'b1;
        preload = 1'b1;
        req_valid = 1'b0;
        req_op = 1'b0;
        req_rs1 = '0;
        req_rs2 = '0;
        req_rd = '0;
        req_wdata = '0;
        for (int i = 0; i < 32; i++) ref_regs[i] = (i == 0) ? '0 : init_val(i);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        preload = 1'b0;

        // Reset state.
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_a", rsp_a, 32'd0);
        check("reset_rsp_b", rsp_b, 32'd0);
        check("reset_wr_done", 32'(wr_done), 32'd0);
        check("reset_rf_we", 32'(rf_we), 32'd0);
        check("reset_rf_addr", 32'(rf_addr), 32'd0);
        check("reset_rf_wdata", rf_wdata, 32'd0);

        // Write then read back, including register 0 as second operand.
        issue(OP_WRITE, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0);
        issue(OP_READ2, 5'd5, 5'd0, 5'd0, 32'd0, 1'b0);
        drain();

        // Register 0 ignores writes and reads as zero.
        issue(OP_WRITE, 5'd0, 5'd0, 5'd0, 32'h12345678, 1'b0);
        issue(OP_READ2, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        drain();

        // Backpressure: response held while rsp_ready stays low.
        rdy_mode = 1;
        issue(OP_READ2, 5'd5, 5'd9, 5'd0, 32'd0, 1'b0);
        wait_rsp();
        a0 = rsp_a;
        b0 = rsp_b;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_a", rsp_a, a0);
            check("bp_rsp_b", rsp_b, b0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rdy_mode = 2;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("bp_release_idle", 32'(req_ready), 32'd1);
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        rdy_mode = 0;
        drain();

        // Sweep all registers.
        for (int i = 1; i < 32; i++) begin
            issue(OP_WRITE, 5'd0, 5'd0, 5'(i), 32'(i) * 32'h01010101, 1'b0);
        end
        for (int i = 0; i < 32; i++) begin
            issue(OP_READ2, 5'(i), 5'(31 - i), 5'd0, 32'd0, 1'b0);
        end
        issue(OP_READ2, 5'd9, 5'd9, 5'd0, 32'd0, 1'b0);
        drain();

        // Reset during the write cycle leaves the register untouched.
        issue(OP_WRITE, 5'd0, 5'd0, 5'd7, 32'hAAAA5555, 1'b1);
        issue(OP_READ2, 5'd7, 5'd6, 5'd0, 32'd0, 1'b0);
        drain();

        // Reset while a response is pending discards it.
        rdy_mode = 1;
        issue(OP_READ2, 5'd3, 5'd4, 5'd0, 32'd0, 1'b0);
        wait_rsp();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", 32'(rsp_valid), 32'd0);
        check("rst_resp_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_rf_we", 32'(rf_we), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rq.delete();
        rdy_mode = 0;

        // Randomised traffic.
        for (int n = 0; n < 40; n++) begin
            r1 = 5'($urandom_range(0, 31));
            r2 = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1)
                issue(OP_WRITE, 5'd0, 5'd0, r1, $urandom, 1'b0);
            else
                issue(OP_READ2, r1, r2, 5'd0, 32'd0, 1'b0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
